// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the equalizer band-filter datapath.
// Also used by the band-gain stage, so the Q1.15 limits live here.
package fir_pkg;
    localparam int NUM_TAPS   = 64;
    localparam int DATA_W     = 16;
    localparam int COEF_W     = 16;
    localparam int ACC_W      = 40;
    localparam int FRAC_W     = DATA_W - 1;
    localparam int Q15_MAX    = 32767;
    localparam int Q15_MIN    = -32768;
    localparam int ROUND_HALF = 1 << 14;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } fir_state_t;
endpackage

// File: rtl/q15_round_sat.sv
// Round-half-up and saturate a wide signed Q.30 sum down to signed Q1.15.
// Latency: purely combinational.
// Backpressure: none.
module q15_round_sat
    import fir_pkg::*;
#(
    parameter int IN_W = ACC_W
) (
    input  logic signed [IN_W-1:0]   acc,
    output logic signed [DATA_W-1:0] q15
);
    localparam logic signed [IN_W-1:0] RND = IN_W'(ROUND_HALF);
    localparam logic signed [IN_W-1:0] HI  = IN_W'(Q15_MAX);
    localparam logic signed [IN_W-1:0] LO  = IN_W'(Q15_MIN);

    logic signed [IN_W-1:0] biased;
    logic signed [IN_W-1:0] shifted;

    assign biased  = acc + RND;
    assign shifted = biased >>> FRAC_W;

    always_comb begin
        if (shifted > HI) begin
            q15 = DATA_W'(Q15_MAX);
        end else if (shifted < LO) begin
            q15 = DATA_W'(Q15_MIN);
        end else begin
            q15 = shifted[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/fir_mac_accumulator.sv
// Serial multiply-accumulate over one tap frame; one rounded, saturated Q1.15 sample per frame.
// Latency: result registered two edges after the phase_63 slot (valid during count 1 of next frame).
// Backpressure: none; inputs are consumed every cycle.
module fir_mac_accumulator #(
    parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
    parameter int DATA_W   = fir_pkg::DATA_W,
    parameter int COEF_W   = fir_pkg::COEF_W,
    parameter int ACC_W    = fir_pkg::ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NUM_TAPS)-1:0]   current_count,
    input  logic                          phase_63,
    input  logic signed [DATA_W-1:0]      i_tap_sample,
    input  logic signed [COEF_W-1:0]      i_coeff,
    output logic signed [DATA_W-1:0]      o_filtered_sample,
    output logic                          o_valid,
    output logic                          o_sync_err
);
    import fir_pkg::*;

    localparam int                CNT_W    = $clog2(NUM_TAPS);
    localparam int                P_W      = DATA_W + COEF_W;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_TAPS - 1);

    fir_state_t              state;
    logic                    at_last;
    logic                    mismatch;
    logic                    aligned;

    logic signed [P_W-1:0]   prod_r;
    logic                    vld_r;
    logic                    first_r;
    logic                    last_r;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] frame_sum;
    logic signed [DATA_W-1:0] rs_q15;

    assign at_last  = (current_count == LAST_IDX);
    assign mismatch = phase_63 ^ at_last;
    assign aligned  = phase_63 & at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_SYNC;
            o_sync_err <= 1'b0;
        end else begin
            o_sync_err <= mismatch;
            if (mismatch) begin
                state <= S_SYNC;
            end else if (aligned) begin
                state <= S_RUN;
            end
        end
    end

    // A mismatching slot never tags a frame end, so a broken frame cannot emit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r            <= '0;
            vld_r             <= 1'b0;
            first_r           <= 1'b0;
            last_r            <= 1'b0;
            acc               <= '0;
            o_filtered_sample <= '0;
            o_valid           <= 1'b0;
        end else begin
            prod_r  <= i_tap_sample * i_coeff;
            vld_r   <= (state == S_RUN) && !mismatch;
            first_r <= (current_count == '0);
            last_r  <= phase_63 && !mismatch;

            if (vld_r) begin
                acc <= first_r ? ACC_W'(prod_r) : acc + ACC_W'(prod_r);
            end

            o_valid <= vld_r && last_r;
            if (vld_r && last_r) begin
                o_filtered_sample <= rs_q15;
            end
        end
    end

    assign frame_sum = acc + ACC_W'(prod_r);

    q15_round_sat #(
        .IN_W (ACC_W)
    ) u_round_sat (
        .acc (frame_sum),
        .q15 (rs_q15)
    );
endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Randomized frames plus directed impulse/rounding/saturation/sync/reset cases,
// checked every cycle against a frame-level arithmetic model.
module tb_fir_mac_accumulator;
    localparam int MAXC = 4096;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [5:0]         cnt = 6'd17;
    logic               phase = 1'b0;
    logic [15:0]        sample = '0;
    logic [15:0]        coeff = '0;
    logic signed [15:0] dout;
    logic               dvalid;
    logic               derr;

    fir_mac_accumulator dut (
        .clk               (clk),
        .rst               (rst),
        .current_count     (cnt),
        .phase_63          (phase),
        .i_tap_sample      (sample),
        .i_coeff           (coeff),
        .o_filtered_sample (dout),
        .o_valid           (dvalid),
        .o_sync_err        (derr)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    bit     exp_valid [MAXC];
    bit     exp_err   [MAXC];
    int     exp_val   [MAXC];
    bit     seen_valid[MAXC];
    bit     seen_err  [MAXC];
    int     seen_dat  [MAXC];
    int     exp_out = 0;
    bit     m_run = 1'b0;
    longint m_sum = 0;
    int     n_aligned = 0;
    int     second_aligned_cyc = -1;
    int     first_valid_cyc = -1;
    logic [15:0] fs[64];
    logic [15:0] fc[64];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int ref_q15(input longint sum);
        longint r;
        r = (sum + 64'sd16384) >>> 15;
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return int'(r);
    endfunction

    // Frame-level model: a frame yields an output iff the previous frame
    // ended aligned and no slot of this frame had a phase/count disagreement.
    task automatic step(input logic [15:0] s, input logic [15:0] k, input bit ph);
        bit     mism;
        longint p;
        if (cyc + 2 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC - 2);
            $fatal(1);
        end
        sample = s;
        coeff  = k;
        phase  = ph;
        if (rst) begin
            mism = ph ^ (cnt == 6'd63);
            p = longint'($signed(s)) * longint'($signed(k));
            if (mism) begin
                exp_err[cyc+1] = 1'b1;
                m_run = 1'b0;
            end else begin
                if (m_run) begin
                    if (cnt == 6'd0) m_sum = 0;
                    m_sum += p;
                    if (ph) begin
                        exp_valid[cyc+2] = 1'b1;
                        exp_val[cyc+2]   = ref_q15(m_sum);
                    end
                end
                if (ph) begin
                    m_run = 1'b1;
                    n_aligned++;
                    if (n_aligned == 2) second_aligned_cyc = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        cnt = cnt + 6'd1;
    endtask

    task automatic pulse_reset(input int n, input bit rand_ph);
        rst = 1'b0;
        for (int i = cyc; i < MAXC; i++) begin
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
        end
        m_run = 1'b0;
        n_aligned = 0;
        second_aligned_cyc = -1;
        first_valid_cyc = -1;
        repeat (n) step(16'($urandom), 16'($urandom), rand_ph ? 1'($urandom) : (cnt == 6'd63));
        rst = 1'b1;
    endtask

    task automatic set_rand_frame();
        logic signed [15:0] t;
        for (int i = 0; i < 64; i++) begin
            fs[i] = 16'($urandom);
            t     = 16'($urandom);
            fc[i] = 16'(t >>> $urandom_range(0, 6));
        end
    endtask

    task automatic run_frame(input int mis_at, output int start);
        start = cyc;
        for (int i = 0; i < 64; i++) step(fs[i], fc[i], (i == 63) || (i == mis_at));
    endtask

    always @(negedge clk) begin
        if (!rst) exp_out = 0;
        else if (exp_valid[cyc]) exp_out = exp_val[cyc];
        seen_valid[cyc] = dvalid;
        seen_err[cyc]   = derr;
        seen_dat[cyc]   = int'(dout);
        if (dvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        check("o_valid", longint'(dvalid), rst ? longint'(exp_valid[cyc]) : 0);
        check("o_sync_err", longint'(derr), rst ? longint'(exp_err[cyc]) : 0);
        check("o_filtered_sample", longint'(dout), longint'(exp_out));
    end

    initial begin
        int f, fi, fz, fh, fp, fr, fn, fm, nerr;

        pulse_reset(20, 1'b1);
        while (cnt != 6'd0) step(16'($urandom), 16'($urandom), cnt == 6'd63);
        repeat (4) begin
            set_rand_frame();
            run_frame(-1, f);
        end
        check("first_valid_after_reset", first_valid_cyc, second_aligned_cyc + 2);

        for (int i = 0; i < 64; i++) begin
            fs[i] = 16'h4000;
            fc[i] = (i == 5) ? 16'h7FFF : 16'h0000;
        end
        run_frame(-1, fi);

        set_rand_frame();
        for (int i = 0; i < 64; i++) fc[i] = 16'h0000;
        fs[0] = 16'hFFFF;
        fc[0] = 16'h4000;
        run_frame(-1, fz);

        fs[0] = 16'h0001;
        run_frame(-1, fh);

        for (int i = 0; i < 64; i++) begin
            fs[i] = 16'h7FFF;
            fc[i] = 16'h7FFF;
        end
        run_frame(-1, fp);

        set_rand_frame();
        fr = cyc;
        for (int i = 0; i < 30; i++) step(fs[i], fc[i], 1'b0);
        pulse_reset(2, 1'b0);
        for (int i = 32; i < 64; i++) step(fs[i], fc[i], i == 63);

        for (int i = 0; i < 64; i++) begin
            fs[i] = 16'h8000;
            fc[i] = 16'h7FFF;
        end
        run_frame(-1, fn);

        set_rand_frame();
        run_frame(-1, f);
        set_rand_frame();
        run_frame(40, fm);
        repeat (4) begin
            set_rand_frame();
            run_frame(-1, f);
        end

        check("impulse_valid", seen_valid[fi+65], 1);
        check("impulse_value", seen_dat[fi+65], 16384);
        check("round_zero_valid", seen_valid[fz+65], 1);
        check("round_zero_value", seen_dat[fz+65], 0);
        check("round_half_up_value", seen_dat[fh+65], 1);
        check("sat_pos_value", seen_dat[fp+65], 32767);
        check("midreset_clears_output", seen_dat[fr+30], 0);
        check("midreset_partial_no_valid", seen_valid[fr+65], 0);
        check("sat_neg_valid", seen_valid[fn+65], 1);
        check("sat_neg_value", seen_dat[fn+65], -32768);
        nerr = 0;
        for (int i = fm; i < fm + 192; i++) nerr += int'(seen_err[i]);
        check("misalign_err_pulses", nerr, 1);
        check("misalign_err_cycle", seen_err[fm+41], 1);
        check("misalign_frame_no_valid", seen_valid[fm+65], 0);
        check("misalign_resume_valid", seen_valid[fm+129], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
